ysyx_23060201_lsu: RTL and testbench

Multi-cycle load/store unit between the execute stage and data memory. It replaces the single-cycle combinational memory port with a request/response handshake to a variable-latency SRAM-style bus. It handles byte/half/word alignment, write-strobe generation, load sign/zero extension and error reporting. The core stalls while req_ready is low; the write-back stage consumes the resp_* pulse.

---
 rtl/ysyx_23060201_lsu.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_23060201_lsu.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_lsu.sv
// ysyx_23060201_lsu: multi-cycle load/store unit between the execute stage
// and a variable-latency SRAM-style data bus.
//
// Each request is latched in IDLE. Illegal accesses complete straight away
// with an error. Legal ones make one bus request (REQ), wait for one bus
// response (WAIT) and then issue a single-cycle completion pulse (RESP).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   execute-stage handshake; the core stalls while
//                         req_ready is low
//   req_wen/addr/wdata    store flag, byte address, LSB-aligned store data
//   req_func3/req_rd      RV32 funct3 and load destination register
//   resp_valid            one-cycle completion pulse
//   resp_rdata/rd/err     formatted load data, destination register, error;
//                         all zero outside the resp_valid cycle
//   bus_req_valid/ready   bus request handshake
//   bus_we/addr/wdata/wstrb  word-aligned request with lane-replicated data
//   bus_rsp_valid/rdata/err  bus response, only sampled in WAIT
//
// Build option:
//   LSU_TIMEOUT_EN        when defined, WAIT gives up after TIMEOUT_CYCLES
//                         cycles and completes with resp_err=1
module ysyx_23060201_lsu #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_func3,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rsp_rdata,
  input  logic                  bus_rsp_err
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;

  // Registered outputs
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]            resp_rd_q, resp_rd_d;
  logic                  resp_err_q, resp_err_d;
  logic                  bus_req_valid_q, bus_req_valid_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]            bus_wstrb_q, bus_wstrb_d;

  // Latched request fields needed after the bus handshake
  logic                  wen_q, wen_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            func3_q, func3_d;
  logic [4:0]            rd_q, rd_d;

  // Combinational helpers
  logic                  illegal_c;
  logic [3:0]            st_wstrb_c;
  logic [DATA_WIDTH-1:0] st_wdata_c;
  logic [15:0]           ld_shift_c;
  logic [DATA_WIDTH-1:0] ld_data_c;

`ifdef LSU_TIMEOUT_EN
  // Wide enough for TIMEOUT_CYCLES, never narrower than 8 bits
  localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
`else
  logic                  unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Illegal funct3 for the direction, or a halfword/word not naturally aligned
  always_comb begin
    illegal_c = 1'b0;
    if (req_wen) begin
      illegal_c = !(req_func3 inside {F3_B, F3_H, F3_W});
    end else begin
      illegal_c = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
                  (req_func3 == 3'b111);
    end
    if ((req_func3[1:0] == 2'b01) && req_addr[0]) begin
      illegal_c = 1'b1;
    end
    if ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      illegal_c = 1'b1;
    end
  end

  // Store lanes: replicate the datum across the word, strobe only its bytes
  always_comb begin
    st_wstrb_c = 4'b1111;
    st_wdata_c = req_wdata;
    unique case (req_func3[1:0])
      2'b00: begin
        st_wstrb_c = 4'b0001 << req_addr[1:0];
        st_wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb_c = 4'b0011 << req_addr[1:0];
        st_wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        st_wstrb_c = 4'b1111;
        st_wdata_c = req_wdata;
      end
    endcase
  end

  // Load formatting: shift the addressed byte/half down, then extend
  always_comb begin
    ld_shift_c = 16'(bus_rsp_rdata >> {off_q, 3'b000});
    unique case (func3_q)
      F3_B:    ld_data_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      F3_BU:   ld_data_c = {24'h000000, ld_shift_c[7:0]};
      F3_H:    ld_data_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      F3_HU:   ld_data_c = {16'h0000, ld_shift_c[15:0]};
      default: ld_data_c = bus_rsp_rdata;
    endcase
  end

  // Next state and next output values; outputs are registered from these
  always_comb begin
    state_d         = state_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = '0;
    resp_rd_d       = '0;
    resp_err_d      = 1'b0;
    bus_req_valid_d = 1'b0;
    bus_we_d        = 1'b0;
    bus_addr_d      = '0;
    bus_wdata_d     = '0;
    bus_wstrb_d     = '0;
    wen_d           = wen_q;
    off_d           = off_q;
    func3_d         = func3_q;
    rd_d            = rd_q;
`ifdef LSU_TIMEOUT_EN
    tmo_d           = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // req_ready_q is low for one cycle after reset; never accept then
        if (req_ready_q && req_valid) begin
          wen_d   = req_wen;
          off_d   = req_addr[1:0];
          func3_d = req_func3;
          rd_d    = req_rd;
          if (illegal_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d         = S_REQ;
            bus_req_valid_d = 1'b1;
            bus_we_d        = req_wen;
            bus_addr_d      = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_wen) begin
              bus_wdata_d = st_wdata_c;
              bus_wstrb_d = st_wstrb_c;
            end
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      S_REQ: begin
        if (bus_req_ready) begin
          state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          // Hold the request stable until the bus accepts it
          bus_req_valid_d = 1'b1;
          bus_we_d        = bus_we_q;
          bus_addr_d      = bus_addr_q;
          bus_wdata_d     = bus_wdata_q;
          bus_wstrb_d     = bus_wstrb_q;
        end
      end

      S_WAIT: begin
        // A response on the limit cycle wins over the timeout
        if (bus_rsp_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          if (bus_rsp_err) begin
            resp_err_d = 1'b1;
          end else if (!wen_q) begin
            resp_rdata_d = ld_data_c;
            resp_rd_d    = rd_q;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if ((tmo_q + TMO_W'(1)) == TMO_W'(TIMEOUT_CYCLES)) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_rd_q       <= '0;
      resp_err_q      <= 1'b0;
      bus_req_valid_q <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wstrb_q     <= '0;
      wen_q           <= 1'b0;
      off_q           <= '0;
      func3_q         <= '0;
      rd_q            <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_rd_q       <= resp_rd_d;
      resp_err_q      <= resp_err_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wstrb_q     <= bus_wstrb_d;
      wen_q           <= wen_d;
      off_q           <= off_d;
      func3_q         <= func3_d;
      rd_q            <= rd_d;
`ifdef LSU_TIMEOUT_EN
      tmo_q           <= tmo_d;
`endif
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_rd       = resp_rd_q;
  assign resp_err      = resp_err_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Testbench for ysyx_23060201_lsu: directed cases plus random load/store
// traffic. A reference model predicts each response and bus request; a bus
// responder and a response monitor check them against queued expectations.
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid, bus_rsp_err;
  logic [31:0] bus_rsp_rdata;

  ysyx_23060201_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_err(resp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One memory operation plus the bus behaviour chosen for it
  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [4:0]  rd;
    int unsigned rdy;
    int unsigned rsp;
    bit          berr;
    logic [31:0] brdata;
  } op_t;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    bit          err;
    int unsigned due;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned rdy;
    int unsigned rsp;
    bit          err;
    logic [31:0] rdata;
  } plan_t;

  exp_t  exp_q[$];
  plan_t bus_q[$];
  int    nvec = 0;
  int    nerr = 0;

  // ---------------- reference model ----------------
  function automatic bit legal_access(input op_t op);
    int size;
    if (op.wen) begin
      if (op.func3 > 3'd2) return 1'b0;
    end else if (op.func3 == 3'd3 || op.func3 >= 3'd6) begin
      return 1'b0;
    end
    size = 1 << op.func3[1:0];
    return (op.addr % size) == 0;
  endfunction

  function automatic logic [31:0] load_value(input op_t op);
    longint unsigned word, field, span;
    int bytes, off;
    bytes = 1 << op.func3[1:0];
    off   = int'(op.addr % 4);
    word  = longint'(op.brdata);
    span  = longint'(1) << (8 * bytes);
    field = (word >> (8 * off)) % span;
    if (!op.func3[2] && bytes < 4 && field >= span / 2)
      return 32'(longint'(field) - longint'(span));
    return 32'(field);
  endfunction

  function automatic void store_lanes(input op_t op, output logic [3:0] strb,
                                      output logic [31:0] data);
    int bytes, off;
    bytes = 1 << op.func3[1:0];
    off   = int'(op.addr % 4);
    strb  = 4'b0000;
    data  = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + bytes) strb[b] = 1'b1;
      data[8*b +: 8] = 8'(op.wdata >> (8 * (b % bytes)));
    end
  endfunction

  function automatic op_t mk(input bit wen, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input int unsigned rdy,
                             input int unsigned rsp, input bit berr,
                             input logic [31:0] brdata);
    op_t op;
    op.wen = wen; op.func3 = f3; op.addr = addr; op.wdata = wdata; op.rd = rd;
    op.rdy = rdy; op.rsp = rsp; op.berr = berr; op.brdata = brdata;
    return op;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input op_t op, input bit expect_resp);
    int unsigned waited;
    exp_t  e;
    plan_t p;
    bit    legal;
    req_valid = 1'b1; req_wen = op.wen; req_addr = op.addr;
    req_wdata = op.wdata; req_func3 = op.func3; req_rd = op.rd;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
    end else begin
      legal   = legal_access(op);
      e.err   = !legal || op.berr;
      e.rdata = (e.err || op.wen) ? 32'h0 : load_value(op);
      e.rd    = (e.err || op.wen) ? 5'd0 : op.rd;
      e.due   = cyc + (legal ? 3 + op.rdy + op.rsp : 1);
      if (expect_resp) exp_q.push_back(e);
      if (legal) begin
        p.we = op.wen; p.addr = op.addr & 32'hFFFF_FFFC;
        store_lanes(op, p.wstrb, p.wdata);
        p.rdy = op.rdy; p.rsp = op.rsp; p.err = op.berr; p.rdata = op.brdata;
        bus_q.push_back(p);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_func3 = 3'($urandom); req_rd = 5'($urandom);
  endtask

  task automatic check_all_zero(input string name);
    nvec++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
        resp_rd !== 5'd0 || resp_err !== 1'b0 || bus_req_valid !== 1'b0 ||
        bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 ||
        bus_wstrb !== 4'h0) begin
      nerr++;
      $display("FAIL %s: got ready=%0b rv=%0b rdata=%h rd=%0d err=%0b bv=%0b we=%0b addr=%h wdata=%h strb=%b, required all 0",
               name, req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
               bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin : bus_model
    plan_t p;
    bit    aborted;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    bus_rsp_err = 1'b0; bus_rsp_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
      if (!rst && bus_req_valid) begin
        if (bus_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_bus_req: addr=%h we=%0b, required no request",
                   bus_addr, bus_we);
        end else begin
          p = bus_q.pop_front();
          aborted = 1'b0;
          for (int k = 0; k <= int'(p.rdy); k++) begin
            if (k > 0) @(negedge clk);
            if (rst) begin aborted = 1'b1; break; end
            nvec++;
            if (bus_req_valid !== 1'b1 || bus_we !== p.we || bus_addr !== p.addr ||
                (p.we && (bus_wstrb !== p.wstrb || bus_wdata !== p.wdata))) begin
              nerr++;
              $display("FAIL bus_req(stall %0d): got v=%0b we=%0b addr=%h strb=%b wdata=%h, required v=1 we=%0b addr=%h strb=%b wdata=%h",
                       k, bus_req_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
                       p.we, p.addr, p.wstrb, p.wdata);
            end
            bus_req_ready = (k == int'(p.rdy));
            // Responses outside WAIT must be ignored by the LSU
            bus_rsp_valid = ($urandom_range(0, 2) == 0);
            bus_rsp_err   = 1'($urandom);
            bus_rsp_rdata = $urandom;
          end
          if (!aborted) begin
            for (int k = 0; k <= int'(p.rsp); k++) begin
              @(negedge clk);
              bus_req_ready = 1'b0;
              if (rst) begin
                bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
                break;
              end
              bus_rsp_valid = (k == int'(p.rsp));
              bus_rsp_err   = (k == int'(p.rsp)) && p.err;
              bus_rsp_rdata = (k == int'(p.rsp)) ? p.rdata : $urandom;
            end
          end
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nvec++;
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_resp: rdata=%h rd=%0d err=%0b at cycle %0d, required no response",
                     resp_rdata, resp_rd, resp_err, cyc);
          end else begin
            e = exp_q.pop_front();
            if (resp_rdata !== e.rdata || resp_rd !== e.rd ||
                resp_err !== e.err || cyc != e.due) begin
              nerr++;
              $display("FAIL resp: got rdata=%h rd=%0d err=%0b cycle=%0d, required rdata=%h rd=%0d err=%0b cycle=%0d",
                       resp_rdata, resp_rd, resp_err, cyc,
                       e.rdata, e.rd, e.err, e.due);
            end
          end
        end else if (resp_rdata !== 32'h0 || resp_rd !== 5'd0 || resp_err !== 1'b0) begin
          nerr++;
          $display("FAIL idle_resp_fields: rdata=%h rd=%0d err=%0b, required all 0",
                   resp_rdata, resp_rd, resp_err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    op_t op;
    int unsigned waited;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_func3 = 3'h0; req_rd = 5'h0;

    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    // LW zero-wait, then LB/LBU sign vs zero extension
    issue(mk(1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd5, 0, 0, 1'b0, 32'hDEAD_BEEF), 1'b1);
    issue(mk(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd6, 0, 0, 1'b0, 32'h8011_2233), 1'b1);
    issue(mk(1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd7, 0, 0, 1'b0, 32'h8011_2233), 1'b1);
    // SH in the upper half with a slow bus handshake
    issue(mk(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd9, 3, 1, 1'b0, 32'h0), 1'b1);
    // Misaligned LW and illegal store funct3: no bus access
    issue(mk(1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd3, 0, 0, 1'b0, 32'h0), 1'b1);
    issue(mk(1'b1, 3'b100, 32'h8000_0000, 32'h1234_5678, 5'd3, 0, 0, 1'b0, 32'h0), 1'b1);
    // Bus error on a load
    issue(mk(1'b0, 3'b010, 32'h8000_000C, 32'h0, 5'd11, 1, 2, 1'b1, 32'hCAFE_F00D), 1'b1);
    // LH/LHU on the upper half
    issue(mk(1'b0, 3'b001, 32'h8000_0012, 32'h0, 5'd12, 0, 1, 1'b0, 32'h9ABC_1234), 1'b1);
    issue(mk(1'b0, 3'b101, 32'h8000_0012, 32'h0, 5'd13, 2, 0, 1'b0, 32'h9ABC_1234), 1'b1);

    // Reset while waiting on a slow response: that response must never appear
    issue(mk(1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd14, 0, 40, 1'b0, 32'h1111_1111), 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    issue(mk(1'b1, 3'b010, 32'h8000_0008, 32'h1234_5678, 5'd15, 0, 0, 1'b0, 32'h0), 1'b1);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      op = mk(1'($urandom), 3'($urandom),
              32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom,
              5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom);
      issue(op, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    nvec++;
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d responses and %0d bus requests outstanding, required 0",
               exp_q.size(), bus_q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
